// File: rtl/game_flow_ctrl.sv
// Round sequencer for the bubble-shooter: IDLE/INIT/PLAY/DONE FSM, BCD round timer,
// BCD score accumulator and Row1 display rendering. Define SCORE_BLANK_EN to blank leading score zeros.
module game_flow_ctrl #(
    parameter int TICK_DIV     = 100_000_000,
    parameter int GAME_SECONDS = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hit,
    input  logic        board_clear,
    output logic        game_en,
    output logic        init_pulse,
    output logic        finished,
    output logic [1:0]  state,
    output logic [7:0]  time_left,
    output logic [39:0] score_row
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [7:0] GS_BCD = 8'(((GAME_SECONDS / 10) * 16) + (GAME_SECONDS % 10));
    localparam logic [4:0] DARK = 5'd31;

    typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, PLAY = 2'd2, DONE = 2'd3} state_t;

    state_t          cur, nxt;
    logic            start_q, armed, start_rise, tick;
    logic [3:0][3:0] score, score_n;
    logic [7:0]      time_n;
    logic [PW-1:0]   presc, presc_n;

    function automatic logic [3:0][3:0] bcd_inc(input logic [3:0][3:0] s);
        logic [3:0][3:0] r;
        logic            c;
        r = s;
        c = 1'b1;
        if (s == 16'h9999) return s;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i] == 4'd9) r[i] = 4'd0;
                else begin
                    r[i] = r[i] + 4'd1;
                    c    = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] t);
        if (t[3:0] == 4'd0) return {t[7:4] - 4'd1, 4'd9};
        return {t[7:4], t[3:0] - 4'd1};
    endfunction

    function automatic logic [39:0] render(input logic [3:0][3:0] s, input logic [7:0] t);
        logic [4:0] d3, d2, d1;
        d3 = {1'b0, s[3]};
        d2 = {1'b0, s[2]};
        d1 = {1'b0, s[1]};
`ifdef SCORE_BLANK_EN
        if (s[3] == 4'd0) d3 = DARK;
        if (s[3] == 4'd0 && s[2] == 4'd0) d2 = DARK;
        if (s[3] == 4'd0 && s[2] == 4'd0 && s[1] == 4'd0) d1 = DARK;
`endif
        return {d3, d2, d1, {1'b0, s[0]}, DARK, DARK, {1'b0, t[7:4]}, {1'b0, t[3:0]}};
    endfunction

    // armed blocks a start held high across reset release until it has been seen low
    assign start_rise = start & ~start_q & armed;
    assign tick       = (presc == PW'(TICK_DIV - 1));

    always_comb begin
        nxt     = cur;
        score_n = score;
        time_n  = time_left;
        presc_n = presc;
        case (cur)
            IDLE: if (start_rise) nxt = INIT;
            INIT: nxt = PLAY;
            PLAY: begin
                if (start_rise) nxt = INIT;
                else begin
                    if (tick) begin
                        presc_n = '0;
                        time_n  = bcd_dec(time_left);
                    end else begin
                        presc_n = presc + PW'(1);
                    end
                    if (hit) score_n = bcd_inc(score);
                    if (board_clear || time_n == 8'h00) nxt = DONE;
                end
            end
            DONE: if (start_rise) nxt = INIT;
            default: nxt = IDLE;
        endcase
        // Clearing on entry into INIT also drops a hit that coincides with a restart
        if (nxt == INIT) begin
            score_n = '0;
            time_n  = GS_BCD;
            presc_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= IDLE;
            start_q   <= 1'b0;
            armed     <= 1'b0;
            score     <= '0;
            time_left <= GS_BCD;
            presc     <= '0;
            score_row <= render('0, GS_BCD);
        end else begin
            cur       <= nxt;
            start_q   <= start;
            armed     <= armed | ~start;
            score     <= score_n;
            time_left <= time_n;
            presc     <= presc_n;
            score_row <= render(score_n, time_n);
        end
    end

    assign state      = cur;
    assign game_en    = (cur == PLAY);
    assign init_pulse = (cur == INIT);
    assign finished   = (cur == DONE);
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: small instance (TICK_DIV=4, 3 s) for flow/timing,
// large instance (TICK_DIV=1000, 99 s) for score saturation.
module tb_game_flow_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, hit, board_clear;
    logic        game_en, init_pulse, finished;
    logic [1:0]  state;
    logic [7:0]  time_left;
    logic [39:0] score_row;
    logic        start2, hit2;
    logic        game_en2, init_pulse2, finished2;
    logic [1:0]  state2;
    logic [7:0]  time_left2;
    logic [39:0] score_row2;
    int          vec = 0;
    int          miss = 0;

    always #5 clk = ~clk;

    game_flow_ctrl #(.TICK_DIV(4), .GAME_SECONDS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .hit(hit), .board_clear(board_clear),
        .game_en(game_en), .init_pulse(init_pulse), .finished(finished),
        .state(state), .time_left(time_left), .score_row(score_row)
    );

    game_flow_ctrl #(.TICK_DIV(1000), .GAME_SECONDS(99)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .hit(hit2), .board_clear(1'b0),
        .game_en(game_en2), .init_pulse(init_pulse2), .finished(finished2),
        .state(state2), .time_left(time_left2), .score_row(score_row2)
    );

    // Expected display row from a decimal score and a BCD time
    function automatic logic [39:0] exp_row(input int s, input logic [7:0] t);
        logic [4:0] d3, d2, d1, d0;
        d3 = 5'(s / 1000);
        d2 = 5'((s / 100) % 10);
        d1 = 5'((s / 10) % 10);
        d0 = 5'(s % 10);
`ifdef SCORE_BLANK_EN
        if (s < 1000) d3 = 5'd31;
        if (s < 100)  d2 = 5'd31;
        if (s < 10)   d1 = 5'd31;
`endif
        return {d3, d2, d1, d0, 5'd31, 5'd31, 1'b0, t[7:4], 1'b0, t[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hit = 1'b0; board_clear = 1'b0;
        start2 = 1'b0; hit2 = 1'b0;
        #3;
        chk("rst_state", 40'(state), 40'd0);
        chk("rst_time", 40'(time_left), 40'h03);
        chk("rst_finished", 40'(finished), 40'd0);
        chk("rst_game_en", 40'(game_en), 40'd0);
        chk("rst_init_pulse", 40'(init_pulse), 40'd0);
        chk("rst_row", score_row, exp_row(0, 8'h03));

        // start held high through reset release must not start a round
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        step(3);
        chk("held_start_idle", 40'(state), 40'd0);
        start = 1'b0;
        step(1);
        chk("start_low_idle", 40'(state), 40'd0);
        start = 1'b1;
        step(1);
        chk("init_state", 40'(state), 40'd1);
        chk("init_pulse_hi", 40'(init_pulse), 40'd1);
        chk("init_game_en_lo", 40'(game_en), 40'd0);
        start = 1'b0;
        step(1);
        chk("play_state", 40'(state), 40'd2);
        chk("play_game_en", 40'(game_en), 40'd1);
        chk("init_pulse_lo", 40'(init_pulse), 40'd0);

        // round timing: decrement every 4 cycles, DONE 12 cycles after PLAY entry
        step(3);
        chk("t_plus3", 40'(time_left), 40'h03);
        step(1);
        chk("t_plus4", 40'(time_left), 40'h02);
        step(4);
        chk("t_plus8", 40'(time_left), 40'h01);
        step(3);
        chk("t_plus11_fin", 40'(finished), 40'd0);
        step(1);
        chk("t_plus12_fin", 40'(finished), 40'd1);
        chk("t_plus12_state", 40'(state), 40'd3);
        chk("t_plus12_time", 40'(time_left), 40'h00);

        hit = 1'b1;
        step(1);
        hit = 1'b0;
        chk("done_hit_ignored", score_row, exp_row(0, 8'h00));

        // restart from DONE, then 12 hits; the 12th lands on the expiry edge
        start = 1'b1;
        step(1);
        chk("restart_done_state", 40'(state), 40'd1);
        chk("restart_done_time", 40'(time_left), 40'h03);
        start = 1'b0;
        step(1);
        hit = 1'b1;
        step(11);
        chk("hits11_row", score_row, exp_row(11, 8'h01));
        chk("hits11_state", 40'(state), 40'd2);
        step(1);
        hit = 1'b0;
        chk("hits12_row", score_row, exp_row(12, 8'h00));
        chk("hits12_state", 40'(state), 40'd3);
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        chk("done_hit2_ignored", score_row, exp_row(12, 8'h00));

        // early end via board_clear at cycle 5 of PLAY
        start = 1'b1;
        step(1);
        chk("restart2_row", score_row, exp_row(0, 8'h03));
        start = 1'b0;
        step(1);
        step(5);
        chk("bc_pre_time", 40'(time_left), 40'h02);
        board_clear = 1'b1;
        step(1);
        board_clear = 1'b0;
        chk("bc_state", 40'(state), 40'd3);
        chk("bc_time", 40'(time_left), 40'h02);
        step(5);
        chk("bc_frozen", 40'(time_left), 40'h02);

        // restart in PLAY with a coincident hit
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        hit = 1'b1;
        step(2);
        chk("play_hits2", score_row, exp_row(2, 8'h03));
        start = 1'b1;
        step(1);
        chk("restart_play_state", 40'(state), 40'd1);
        chk("restart_play_row", score_row, exp_row(0, 8'h03));
        start = 1'b0; hit = 1'b0;
        step(1);
        step(5);
        chk("pre_async_time", 40'(time_left), 40'h02);

        // asynchronous reset mid-cycle
        #3 rst = 1'b1;
        #1;
        chk("async_state", 40'(state), 40'd0);
        chk("async_time", 40'(time_left), 40'h03);
        chk("async_game_en", 40'(game_en), 40'd0);
        chk("async_row", score_row, exp_row(0, 8'h03));
        #1 rst = 1'b0;
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        step(1);
        chk("idle_hit_ignored", score_row, exp_row(0, 8'h03));

        // saturation on the large instance: 10000 hits from 0000
        start2 = 1'b1;
        step(1);
        chk("sat_init", 40'(state2), 40'd1);
        step(1);
        hit2 = 1'b1;
        step(10000);
        hit2 = 1'b0;
        chk("sat_row", score_row2, exp_row(9999, 8'h89));
        chk("sat_state", 40'(state2), 40'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
